// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / flush / redirect sequencer for the 5-stage RV32I core.
// Owns the multi-cycle waits: divider, data-memory handshake and debug-halt drain.
// Optional build macro PIPE_CTRL_PERF_EN adds the stalled-cycle and flush-event
// counters. When it is undefined, both counter outputs read 0 and no counter flops exist.
module pipe_ctrl #(
    parameter int DIV_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        div_start_i,
    input  logic        div_done_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        halt_req_i,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        stall_ex_mem_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        halt_ack_o,
    output logic        div_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int MAXC  = (DIV_TIMEOUT > DRAIN_CYCLES) ? DIV_TIMEOUT : DRAIN_CYCLES;
    localparam int CNT_W = ($clog2(MAXC + 1) > 7) ? $clog2(MAXC + 1) : 7;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DIV_WAIT = 3'd1,
        MEM_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;

    // A memory access is outstanding this cycle and has not completed.
    assign mem_stall = mem_req_i & ~mem_ack_i;

    // State and wait counter; reset abandons any divide, access or drain in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end else if (!jump_en_i) begin
                    // A taken jump masks divide launch, load-use and halt this cycle.
                    if (div_start_i) begin
                        state_d = DIV_WAIT;
                        cnt_d   = CNT_ONE;
                    end else if (!load_use_i && halt_req_i) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DIV_WAIT: begin
                // Divider completion wins over the watchdog in the same cycle.
                if (div_done_i || (cnt_q == DIV_LAST)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) state_d = RUN;
            end
            DRAIN: begin
                // A memory wait freezes the drain; those cycles do not count.
                if (!mem_stall) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = HALTED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            HALTED: begin
                if (!halt_req_i) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall, flush, redirect and status outputs; all forced low while reset is held.
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        jump_en_o      = 1'b0;
        jump_addr_o    = 32'b0;
        halt_ack_o     = 1'b0;
        div_timeout_o  = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    // ex holds the jump and re-presents it once memory completes.
                    stall_pc_o     = 1'b1;
                    stall_if_id_o  = 1'b1;
                    stall_id_ex_o  = 1'b1;
                    stall_ex_mem_o = 1'b1;
                end else if (jump_en_i) begin
                    jump_en_o     = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (div_start_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                end else if (load_use_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (halt_req_i) begin
                    stall_pc_o    = 1'b1;
                    flush_if_id_o = 1'b1;
                end
            end
            DIV_WAIT: begin
                if (!div_done_i) begin
                    if (cnt_q == DIV_LAST) begin
                        div_timeout_o = 1'b1;
                    end else begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        stall_id_ex_o = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_ack_i) begin
                    stall_pc_o     = 1'b1;
                    stall_if_id_o  = 1'b1;
                    stall_id_ex_o  = 1'b1;
                    stall_ex_mem_o = 1'b1;
                end
            end
            DRAIN: begin
                stall_pc_o = 1'b1;
                // if_id is frozen during a memory wait, so it must not also be flushed.
                if (mem_stall) begin
                    stall_if_id_o  = 1'b1;
                    stall_id_ex_o  = 1'b1;
                    stall_ex_mem_o = 1'b1;
                end else begin
                    flush_if_id_o = 1'b1;
                end
            end
            HALTED: begin
                halt_ack_o    = 1'b1;
                stall_pc_o    = 1'b1;
                flush_if_id_o = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            stall_pc_o     = 1'b0;
            stall_if_id_o  = 1'b0;
            stall_id_ex_o  = 1'b0;
            stall_ex_mem_o = 1'b0;
            flush_if_id_o  = 1'b0;
            flush_id_ex_o  = 1'b0;
            jump_en_o      = 1'b0;
            jump_addr_o    = 32'b0;
            halt_ack_o     = 1'b0;
            div_timeout_o  = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        any_stall, any_flush;

    assign any_stall   = stall_pc_o | stall_if_id_o | stall_id_ex_o | stall_ex_mem_o;
    assign any_flush   = flush_if_id_o | flush_id_ex_o;
    assign stall_cnt_d = stall_cnt_q + {31'b0, any_stall};
    assign flush_cnt_d = flush_cnt_q + {31'b0, any_flush};

    // Free-running performance counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'b0;
            flush_cnt_q <= 32'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'b0;
    assign flush_cnt_o = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the sequencer kept in this file.
module tb_pipe_ctrl;

    localparam int DIV_TIMEOUT  = 64;
    localparam int DRAIN_CYCLES = 3;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        div_start_i;
    logic        div_done_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        halt_req_i;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        stall_ex_mem_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        halt_ack_o;
    logic        div_timeout_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    pipe_ctrl #(
        .DIV_TIMEOUT (DIV_TIMEOUT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .load_use_i    (load_use_i),
        .div_start_i   (div_start_i),
        .div_done_i    (div_done_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .halt_req_i    (halt_req_i),
        .stall_pc_o    (stall_pc_o),
        .stall_if_id_o (stall_if_id_o),
        .stall_id_ex_o (stall_id_ex_o),
        .stall_ex_mem_o(stall_ex_mem_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .halt_ack_o    (halt_ack_o),
        .div_timeout_o (div_timeout_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;

    // Behavioural model: which wait the core is in, and how far along it is.
    bit m_memwait, m_div, m_drain, m_halted;
    int m_div_elapsed, m_drain_done;
    int m_stall_cycles, m_flush_cycles;
    bit n_memwait, n_div, n_drain, n_halted;
    int n_div_elapsed, n_drain_done;

    bit          e_spc, e_sif, e_sie, e_sem, e_fif, e_fie, e_jen, e_ack, e_tmo;
    logic [31:0] e_jaddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            failed_cnt++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stall_count();
`ifdef PIPE_CTRL_PERF_EN
        return 32'(m_stall_cycles);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush_count();
`ifdef PIPE_CTRL_PERF_EN
        return 32'(m_flush_cycles);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_clear();
        m_memwait = 0; m_div = 0; m_drain = 0; m_halted = 0;
        m_div_elapsed = 0; m_drain_done = 0;
        m_stall_cycles = 0; m_flush_cycles = 0;
    endtask

    // Expected outputs this cycle and the model's situation after the next edge.
    task automatic model_eval();
        bit mem_busy;
        mem_busy = mem_req_i && !mem_ack_i;
        {e_spc, e_sif, e_sie, e_sem, e_fif, e_fie, e_jen, e_ack, e_tmo} = '0;
        e_jaddr = 32'd0;
        n_memwait = m_memwait; n_div = m_div; n_drain = m_drain; n_halted = m_halted;
        n_div_elapsed = m_div_elapsed; n_drain_done = m_drain_done;
        if (m_halted) begin
            e_ack = 1; e_spc = 1; e_fif = 1;
            if (!halt_req_i) n_halted = 0;
        end else if (m_drain) begin
            e_spc = 1;
            if (mem_busy) begin
                e_sif = 1; e_sie = 1; e_sem = 1;
            end else begin
                e_fif = 1;
                if (m_drain_done == DRAIN_CYCLES) begin
                    n_drain = 0; n_halted = 1;
                end else begin
                    n_drain_done = m_drain_done + 1;
                end
            end
        end else if (m_div) begin
            if (div_done_i) begin
                n_div = 0;
            end else if (m_div_elapsed == DIV_TIMEOUT) begin
                e_tmo = 1; n_div = 0;
            end else begin
                e_spc = 1; e_sif = 1; e_sie = 1;
                n_div_elapsed = m_div_elapsed + 1;
            end
        end else if (m_memwait) begin
            if (mem_ack_i) n_memwait = 0;
            else begin
                e_spc = 1; e_sif = 1; e_sie = 1; e_sem = 1;
            end
        end else if (mem_busy) begin
            e_spc = 1; e_sif = 1; e_sie = 1; e_sem = 1;
            n_memwait = 1;
        end else if (jump_en_i) begin
            e_jen = 1; e_jaddr = jump_addr_i; e_fif = 1; e_fie = 1;
        end else if (div_start_i) begin
            e_spc = 1; e_sif = 1; e_sie = 1;
            n_div = 1; n_div_elapsed = 1;
        end else if (load_use_i) begin
            e_spc = 1; e_sif = 1; e_fie = 1;
        end else if (halt_req_i) begin
            e_spc = 1; e_fif = 1;
            n_drain = 1; n_drain_done = 1;
        end
    endtask

    task automatic check_outputs();
        chk("stall_pc", 32'(stall_pc_o), 32'(e_spc));
        chk("stall_if_id", 32'(stall_if_id_o), 32'(e_sif));
        chk("stall_id_ex", 32'(stall_id_ex_o), 32'(e_sie));
        chk("stall_ex_mem", 32'(stall_ex_mem_o), 32'(e_sem));
        chk("flush_if_id", 32'(flush_if_id_o), 32'(e_fif));
        chk("flush_id_ex", 32'(flush_id_ex_o), 32'(e_fie));
        chk("jump_en", 32'(jump_en_o), 32'(e_jen));
        chk("jump_addr", jump_addr_o, e_jaddr);
        chk("halt_ack", 32'(halt_ack_o), 32'(e_ack));
        chk("div_timeout", 32'(div_timeout_o), 32'(e_tmo));
        chk("stall_cnt", stall_cnt_o, exp_stall_count());
        chk("flush_cnt", flush_cnt_o, exp_flush_count());
    endtask

    // One clock: check mid-cycle, then advance the model at the edge.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        check_outputs();
        @(posedge clk);
        if (e_spc || e_sif || e_sie || e_sem) m_stall_cycles++;
        if (e_fif || e_fie) m_flush_cycles++;
        m_memwait = n_memwait; m_div = n_div; m_drain = n_drain; m_halted = n_halted;
        m_div_elapsed = n_div_elapsed; m_drain_done = n_drain_done;
        #1;
    endtask

    task automatic idle();
        jump_en_i = 0; jump_addr_i = 32'd0; load_use_i = 0; div_start_i = 0;
        div_done_i = 0; mem_req_i = 0; mem_ack_i = 0; halt_req_i = 0;
    endtask

    // Asynchronous reset away from the clock edge; outputs must drop at once.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_clear();
        {e_spc, e_sif, e_sie, e_sem, e_fif, e_fie, e_jen, e_ack, e_tmo} = '0;
        e_jaddr = 32'd0;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        model_clear();
        rst = 1'b1;
        // Outputs stay low under reset even with active requests.
        jump_en_i = 1; jump_addr_i = 32'hDEAD_BEEF; halt_req_i = 1; load_use_i = 1;
        #2;
        apply_reset();
        idle();
        cycle();

        // Taken jump: redirect and double flush for one cycle.
        jump_en_i = 1; jump_addr_i = 32'h0000_0100;
        #1;
        chk("jump_addr_direct", jump_addr_o, 32'h0000_0100);
        cycle();
        idle();
        cycle();

        // Load-use: a single bubble.
        load_use_i = 1;
        cycle();
        idle();
        cycle();
        chk("perf_stall_direct", stall_cnt_o, exp_stall_count());
        chk("perf_flush_direct", flush_cnt_o, exp_flush_count());

        // Divide completing on the 10th cycle after launch.
        div_start_i = 1;
        cycle();
        div_start_i = 0;
        repeat (9) cycle();
        div_done_i = 1;
        cycle();
        idle();
        cycle();

        // Divide that never completes: watchdog fires.
        div_start_i = 1;
        cycle();
        div_start_i = 0;
        repeat (70) cycle();

        // Memory wait with a jump held in ex.
        mem_req_i = 1; jump_en_i = 1; jump_addr_i = 32'h0000_2000;
        repeat (4) cycle();
        mem_ack_i = 1;
        cycle();
        mem_req_i = 0; mem_ack_i = 0;
        cycle();
        idle();
        cycle();

        // Full halt: drain, acknowledge, release.
        halt_req_i = 1;
        repeat (6) cycle();
        halt_req_i = 0;
        repeat (3) cycle();

        // Halt request withdrawn mid-drain.
        halt_req_i = 1;
        repeat (2) cycle();
        halt_req_i = 0;
        repeat (5) cycle();

        // Drain frozen by an outstanding memory access.
        halt_req_i = 1;
        cycle();
        mem_req_i = 1;
        repeat (2) cycle();
        mem_req_i = 0;
        repeat (5) cycle();
        idle();
        cycle();

        // Reset in the middle of a drain.
        halt_req_i = 1;
        repeat (2) cycle();
        apply_reset();
        idle();
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            jump_en_i   = ($urandom_range(0, 4) == 0);
            jump_addr_i = $urandom;
            load_use_i  = ($urandom_range(0, 4) == 0);
            div_start_i = ($urandom_range(0, 19) == 0);
            div_done_i  = ($urandom_range(0, 15) == 0);
            mem_req_i   = ($urandom_range(0, 3) == 0);
            mem_ack_i   = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 24) == 0) halt_req_i = ~halt_req_i;
            if ($urandom_range(0, 499) == 0) apply_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
